// File: rtl/rotate_result_buffer_if.sv
// Bus bundle between the rotate stage / consumer and the result buffer.
// Signal names match the buffer's documented port list.
interface rotate_result_buffer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] data_in;
  logic             in_en;
  logic             rd_en;
  logic             clr_flags;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  // in_en/rd_en are requests; a write is taken when not full or when a pop
  // is taken in the same cycle, a pop is taken when not empty.
  modport master (
    output data_in, in_en, rd_en, clr_flags,
    input  data_out, valid, full, empty, count, overflow, underflow
  );

  modport slave (
    input  data_in, in_en, rd_en, clr_flags,
    output data_out, valid, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/rotate_result_buffer.sv
// First-word-fall-through FIFO capturing rotate-stage results, with sticky
// overflow/underflow flags and an asynchronous active-high reset.
module rotate_result_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  rotate_result_buffer_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_wr;
  logic w_ovf_evt;
  logic w_udf_evt;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = bus.rd_en & ~w_empty;
  assign w_wr      = bus.in_en & (~w_full | w_pop);
  assign w_ovf_evt = bus.in_en & ~w_wr;
  assign w_udf_evt = bus.rd_en & w_empty;

  // Storage is not reset: entries are masked off the output while empty.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A new event in a clearing cycle keeps its flag set.
      r_overflow  <= (r_overflow  & ~bus.clr_flags) | w_ovf_evt;
      r_underflow <= (r_underflow & ~bus.clr_flags) | w_udf_evt;
    end
  end

  assign bus.data_out  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.valid     = ~w_empty;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
endmodule
